// File: rtl/pio_irq_if.sv
// rtl/pio_irq_if.sv - register bus bundle for the pio_irq slave
interface pio_irq_if #(
  parameter int pADDR_BITS = 4
);
  logic [pADDR_BITS-1:0] iADDRESS;
  logic                  iWRITE;
  logic                  iREAD;
  logic [31:0]           iWRITE_DATA;
  logic [31:0]           oREAD_DATA;

  modport master (
    output iADDRESS,
    output iWRITE,
    output iREAD,
    output iWRITE_DATA,
    input  oREAD_DATA
  );

  modport slave (
    input  iADDRESS,
    input  iWRITE,
    input  iREAD,
    input  iWRITE_DATA,
    output oREAD_DATA
  );
endinterface

// File: rtl/pio_irq.sv
// rtl/pio_irq.sv - GPIO block with pin mux select, edge capture and masked interrupt
module pio_irq #(
  parameter int pBITS        = 32,
  parameter int pMUX_BITS    = 2,
  parameter int pSYNC_STAGES = 2,
  parameter int pADDR_BITS   = 4
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  pio_irq_if.slave                   bus,
  input  logic [pBITS-1:0]           iPIO,
  output logic [pBITS-1:0]           oPIO,
  output logic [pBITS-1:0]           oDIR,
  output logic [pBITS*pMUX_BITS-1:0] oMUXSEL,
  output logic                       oIRQ
);

  // Edge detection stays off until the sync chain and prev have both been
  // refilled from live pins, so pins high at reset do not look like edges.
  localparam int cWARM   = pSYNC_STAGES + 1;
  localparam int cWARM_W = $clog2(cWARM + 1);

  logic [pBITS-1:0]   r_sync [pSYNC_STAGES];
  logic [pBITS-1:0]   r_prev;
  logic [pBITS-1:0]   r_pio;
  logic [pBITS-1:0]   r_dir;
  logic [pBITS-1:0]   r_mask;
  logic [pBITS-1:0]   r_cap;
  logic [pBITS-1:0]   r_rise;
  logic [pBITS-1:0]   r_fall;
  logic [pBITS-1:0]   r_mux [pMUX_BITS];
  logic [cWARM_W-1:0] r_warm;
  logic [31:0]        r_rdata;
  logic               r_irq;

  logic [31:0]        w_addr;
  logic [pBITS-1:0]   w_wd;
  logic [pBITS-1:0]   w_sync;
  logic               w_warm;
  logic [pBITS-1:0]   w_rise;
  logic [pBITS-1:0]   w_fall;
  logic [pBITS-1:0]   w_w1c;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_addr   = 32'(bus.iADDRESS);
  assign w_wd     = bus.iWRITE_DATA[pBITS-1:0];
  assign w_unused = &{1'b0, bus.iWRITE_DATA};
  assign w_sync   = r_sync[pSYNC_STAGES-1];
  assign w_warm   = (r_warm == cWARM_W'(cWARM));
  assign w_rise   = w_sync & ~r_prev & r_rise & {pBITS{w_warm}};
  assign w_fall   = ~w_sync & r_prev & r_fall & {pBITS{w_warm}};
  assign w_w1c    = (bus.iWRITE && (w_addr == 32'd6)) ? w_wd : '0;

  assign oPIO           = r_pio;
  assign oDIR           = r_dir;
  assign oIRQ           = r_irq;
  assign bus.oREAD_DATA = r_rdata;

  for (genvar gk = 0; gk < pMUX_BITS; gk++) begin : g_mux_out
    assign oMUXSEL[gk*pBITS +: pBITS] = r_mux[gk];
  end

  // Input synchroniser chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < pSYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= iPIO;
      for (int i = 1; i < pSYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  // Warm-up counter: saturates once the input path holds only post-reset samples.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_warm <= '0;
    end else if (!w_warm) begin
      r_warm <= r_warm + 1'b1;
    end
  end

  // Register writes; CAP is handled separately because edges also update it.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_pio  <= '0;
      r_dir  <= '0;
      r_mask <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int k = 0; k < pMUX_BITS; k++) r_mux[k] <= '0;
    end else if (bus.iWRITE) begin
      case (w_addr)
        32'd0:   r_pio  <= w_wd;
        32'd1:   r_dir  <= w_wd;
        32'd2:   r_pio  <= r_pio & ~w_wd;
        32'd3:   r_pio  <= r_pio | w_wd;
        32'd4:   r_pio  <= r_pio ^ w_wd;
        32'd5:   r_mask <= w_wd;
        32'd7:   r_rise <= w_wd;
        32'd8:   r_fall <= w_wd;
        default: ;
      endcase
      for (int k = 0; k < pMUX_BITS; k++) begin
        if (w_addr == 32'(9 + k)) r_mux[k] <= w_wd;
      end
    end
  end

  // Captured edges: write-one-to-clear, with a same-cycle new edge winning.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_w1c) | w_rise | w_fall;
    end
  end

  // Level interrupt from the registered CAP/MASK state.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_cap & r_mask);
    end
  end

  // Read mux sees pre-write register values, so read-during-write returns old data.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      32'd0:               w_rdata[pBITS-1:0] = w_sync;
      32'd1:               w_rdata[pBITS-1:0] = r_dir;
      32'd2, 32'd3, 32'd4: w_rdata[pBITS-1:0] = r_pio;
      32'd5:               w_rdata[pBITS-1:0] = r_mask;
      32'd6:               w_rdata[pBITS-1:0] = r_cap;
      32'd7:               w_rdata[pBITS-1:0] = r_rise;
      32'd8:               w_rdata[pBITS-1:0] = r_fall;
      default:             ;
    endcase
    for (int k = 0; k < pMUX_BITS; k++) begin
      if (w_addr == 32'(9 + k)) w_rdata[pBITS-1:0] = r_mux[k];
    end
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_rdata <= '0;
    end else if (bus.iREAD) begin
      r_rdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_pio_irq.sv
// tb/tb_pio_irq.sv - scoreboard bench for pio_irq at 32-bit and 8-bit widths
module tb_pio_irq;

  logic        clk;
  logic        rst_n;
  logic [31:0] pio32_in;
  logic [31:0] pio32_out;
  logic [31:0] dir32;
  logic [63:0] mux32;
  logic        irq32;
  logic [7:0]  pio8_in;
  logic [7:0]  pio8_out;
  logic [7:0]  dir8;
  logic [15:0] mux8;
  logic        irq8;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  pio_irq_if #(.pADDR_BITS(4)) bus32 ();
  pio_irq_if #(.pADDR_BITS(4)) bus8 ();

  pio_irq #(.pBITS(32), .pMUX_BITS(2), .pSYNC_STAGES(2), .pADDR_BITS(4)) dut32 (
    .iCLK(clk), .iRESET(rst_n), .bus(bus32), .iPIO(pio32_in),
    .oPIO(pio32_out), .oDIR(dir32), .oMUXSEL(mux32), .oIRQ(irq32)
  );

  pio_irq #(.pBITS(8), .pMUX_BITS(2), .pSYNC_STAGES(2), .pADDR_BITS(4)) dut8 (
    .iCLK(clk), .iRESET(rst_n), .bus(bus8), .iPIO(pio8_in),
    .oPIO(pio8_out), .oDIR(dir8), .oMUXSEL(mux8), .oIRQ(irq8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Entered at a negedge; holds the strobes across exactly one posedge.
  task automatic drive(input bit s, input int a, input logic [31:0] d, input bit we, input bit re);
    if (s) begin
      bus8.iADDRESS = 4'(a); bus8.iWRITE_DATA = d; bus8.iWRITE = we; bus8.iREAD = re;
    end else begin
      bus32.iADDRESS = 4'(a); bus32.iWRITE_DATA = d; bus32.iWRITE = we; bus32.iREAD = re;
    end
    @(negedge clk);
    bus8.iWRITE = 1'b0; bus8.iREAD = 1'b0;
    bus32.iWRITE = 1'b0; bus32.iREAD = 1'b0;
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, {32'd0, e.sel ? bus8.oREAD_DATA : bus32.oREAD_DATA}, {32'd0, e.exp});
    end
  endtask

  task automatic wr(input bit s, input int a, input logic [31:0] d);
    drive(s, a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input bit s, input int a, input logic [31:0] exp, input string tag);
    sb_q.push_back('{tag, s, exp});
    drive(s, a, 32'd0, 1'b0, 1'b1);
    pop_check();
  endtask

  task automatic rw(input int a, input logic [31:0] d, input logic [31:0] exp, input string tag);
    sb_q.push_back('{tag, 1'b0, exp});
    drive(1'b0, a, d, 1'b1, 1'b1);
    pop_check();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    pio32_in = '1;
    pio8_in = '1;
    bus32.iADDRESS = '0; bus32.iWRITE = 1'b0; bus32.iREAD = 1'b0; bus32.iWRITE_DATA = '0;
    bus8.iADDRESS = '0;  bus8.iWRITE = 1'b0;  bus8.iREAD = 1'b0;  bus8.iWRITE_DATA = '0;

    repeat (3) @(negedge clk);
    chk("rst_pio", {32'd0, pio32_out}, 64'd0);
    chk("rst_mux", mux32, 64'd0);
    chk("rst_irq", {63'd0, irq32}, 64'd0);
    chk("rst_rdata", {32'd0, bus32.oREAD_DATA}, 64'd0);

    // Pins high through reset must not produce edges.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wr(0, 7, 32'hFFFF_FFFF);
    wr(0, 8, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rd(0, 6, 32'h0, "t1_cap");
    chk("t1_irq", {63'd0, irq32}, 64'd0);
    rd(0, 0, 32'hFFFF_FFFF, "t1_data_sync");

    // Set/clear/toggle arithmetic and read-during-write.
    wr(0, 0, 32'h0000_00F0);
    rw(3, 32'h0000_000F, 32'h0000_00F0, "t2_rw_old");
    wr(0, 2, 32'h0000_0030);
    wr(0, 4, 32'h0000_0101);
    chk("t2_opio", {32'd0, pio32_out}, 64'h1CE);
    for (int a = 2; a <= 4; a++) rd(0, a, 32'h0000_01CE, $sformatf("t2_rd%0d", a));
    wr(0, 1, 32'h0000_FFFF);
    chk("t2_dir", {32'd0, dir32}, 64'hFFFF);
    rd(0, 1, 32'h0000_FFFF, "t2_rd_dir");

    // Quiet the pins with capture disabled, then rising edge on bit 0.
    wr(0, 7, 32'h0);
    wr(0, 8, 32'h0);
    pio32_in = 32'h0;
    repeat (5) @(negedge clk);
    wr(0, 6, 32'hFFFF_FFFF);
    rd(0, 6, 32'h0, "t3_cap_quiet");
    wr(0, 7, 32'h1);
    wr(0, 5, 32'h1);
    pio32_in = 32'h1;
    repeat (3) @(negedge clk);
    chk("t3_irq_early", {63'd0, irq32}, 64'd0);
    @(negedge clk);
    chk("t3_irq", {63'd0, irq32}, 64'd1);
    rd(0, 6, 32'h1, "t3_cap");
    wr(0, 6, 32'h1);
    chk("t3_irq_hold", {63'd0, irq32}, 64'd1);
    @(negedge clk);
    chk("t3_irq_clr", {63'd0, irq32}, 64'd0);

    // Falling edge on bit 1 coinciding with its W1C: set wins.
    pio32_in = 32'h3;
    repeat (4) @(negedge clk);
    wr(0, 8, 32'h2);
    wr(0, 5, 32'h2);
    pio32_in = 32'h1;
    repeat (4) @(negedge clk);
    chk("t4_irq_first", {63'd0, irq32}, 64'd1);
    pio32_in = 32'h3;
    repeat (4) @(negedge clk);
    pio32_in = 32'h1;
    repeat (2) @(negedge clk);
    wr(0, 6, 32'h2);
    rd(0, 6, 32'h2, "t4_cap_set_wins");
    chk("t4_irq_stays", {63'd0, irq32}, 64'd1);
    wr(0, 5, 32'h0);
    chk("t4_mask_lag", {63'd0, irq32}, 64'd1);
    @(negedge clk);
    chk("t4_mask_off", {63'd0, irq32}, 64'd0);

    // Mux select words and unmapped addresses.
    wr(0, 9, 32'hAAAA_AAAA);
    wr(0, 10, 32'h5555_5555);
    chk("t5_muxsel", mux32, {32'h5555_5555, 32'hAAAA_AAAA});
    rd(0, 9, 32'hAAAA_AAAA, "t5_rd_mux0");
    rd(0, 10, 32'h5555_5555, "t5_rd_mux1");
    for (int a = 11; a <= 15; a++) begin
      wr(0, a, 32'hFFFF_FFFF);
      rd(0, a, 32'h0, $sformatf("t5_rd_unmapped%0d", a));
    end
    chk("t5_mux_kept", mux32, {32'h5555_5555, 32'hAAAA_AAAA});
    chk("t5_pio_kept", {32'd0, pio32_out}, 64'h1CE);
    chk("t5_dir_kept", {32'd0, dir32}, 64'hFFFF);

    // Narrow instance: upper write bits ignored, readback zero-extended.
    wr(1, 0, 32'hFFFF_FF5A);
    chk("t6_opio8", {56'd0, pio8_out}, 64'h5A);
    rd(1, 3, 32'h0000_005A, "t6_rd8_set");
    rd(1, 0, 32'h0000_00FF, "t6_rd8_sync");

    // Asynchronous reset in the middle of bus activity.
    bus32.iADDRESS = 4'd0; bus32.iWRITE_DATA = 32'h1234_5678; bus32.iWRITE = 1'b1;
    bus8.iADDRESS = 4'd3;  bus8.iREAD = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pio32", {32'd0, pio32_out}, 64'd0);
    chk("t6_rst_dir32", {32'd0, dir32}, 64'd0);
    chk("t6_rst_mux32", mux32, 64'd0);
    chk("t6_rst_rd32", {32'd0, bus32.oREAD_DATA}, 64'd0);
    chk("t6_rst_irq32", {63'd0, irq32}, 64'd0);
    chk("t6_rst_pio8", {56'd0, pio8_out}, 64'd0);
    chk("t6_rst_rd8", {32'd0, bus8.oREAD_DATA}, 64'd0);
    @(negedge clk);
    bus32.iWRITE = 1'b0; bus8.iREAD = 1'b0;
    chk("t6_rst_no_write", {32'd0, pio32_out}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pio_irq.md
Name: pio_irq

Overview:
- Parametrised general-purpose I/O block with an Avalon-style register slave.
- Provides per-bit output data, direction, set/clear/toggle and pin-mux select.
- Adds input synchronisation, programmable rising/falling edge capture, and a masked, level-sensitive interrupt output.
- Sits between the soft-core bus and the FPGA pin mux; `oMUXSEL` drives the mux and `oIRQ` goes to the interrupt controller.

Parameters:
- `pBITS`, 32, number of I/O bits; legal range 1..32.
- `pMUX_BITS`, 2, mux-select bits per I/O; legal range 1..4.
- `pSYNC_STAGES`, 2, input synchroniser depth; legal range 2..4.
- `pADDR_BITS`, 4, word address width; 9+`pMUX_BITS` must not exceed 2^`pADDR_BITS`.

Ports:
- `iCLK`  in  1  single system clock.
- `iRESET`  in  1  asynchronous, active-low reset.
- `iADDRESS`  in  `pADDR_BITS`  word address.
- `iWRITE`  in  1  write strobe.
- `iREAD`  in  1  read strobe.
- `iWRITE_DATA`  in  32  write data; only bits [`pBITS`-1:0] are used.
- `oREAD_DATA`  out  32  registered read data, zero-extended.
- `iPIO`  in  `pBITS`  asynchronous pin inputs.
- `oPIO`  out  `pBITS`  output data.
- `oDIR`  out  `pBITS`  direction per bit, 1 = output.
- `oMUXSEL`  out  `pBITS`*`pMUX_BITS`  mux select, word k occupies bits [(k+1)*`pBITS`-1 : k*`pBITS`].
- `oIRQ`  out  1  interrupt request, active-high.

Behaviour:
- Reset (iRESET=0, asynchronous): `oPIO`, `oDIR`, `oMUXSEL`, `oREAD_DATA`, `oIRQ` and all internal registers go to 0. Internal registers are the sync chain, prev sample, CAP, MASK, RISE, FALL and the warm-up counter. Reset mid-transaction aborts it; no partial writes.
- Input path: `iPIO` passes through `pSYNC_STAGES` flops to give `sync`. `prev` is `sync` delayed by one cycle.
- Edge detection:
  - `rise` = `sync` & ~`prev` & RISE; `fall` = ~`sync` & `prev` & FALL.
  - Edge detection is suppressed until a warm-up counter reaches `pSYNC_STAGES`+1 cycles after reset release. This prevents false edges from pins that are high at reset.
- Register map (word address):
  - 0 DATA: W `oPIO` <= wd; R `sync`.
  - 1 DIR: W/R `oDIR`.
  - 2 CLR: W `oPIO` <= `oPIO`&~wd; R `oPIO`.
  - 3 SET: W `oPIO` <= `oPIO`|wd; R `oPIO`.
  - 4 TOGGLE: W `oPIO` <= `oPIO`^wd; R `oPIO`.
  - 5 MASK: W/R interrupt mask.
  - 6 CAP: R captured-edge flags; W1C (bits written 1 clear, 0 leave).
  - 7 RISE: W/R rising-edge enable.
  - 8 FALL: W/R falling-edge enable.
  - 9..8+`pMUX_BITS` MUXk: W/R `oMUXSEL` word k = addr-9.
  - All other addresses: writes ignored, reads return 0.
- Bus timing:
  - Zero wait states; writes take effect on the clock edge where `iWRITE`=1.
  - `oREAD_DATA` updates on the edge where `iREAD`=1 (1-cycle latency) and holds its value otherwise.
  - A read in the same cycle as a write to the same address returns the pre-write value.
- CAP update per bit each cycle: CAP <= (CAP & ~w1c) | rise | fall. A new edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
- `oIRQ` is registered: `oIRQ` <= |(CAP & MASK). It stays asserted until the relevant CAP bits are cleared or masked. Changing MASK affects `oIRQ` on the next cycle.
- Latency: a pin change is visible in a DATA read after `pSYNC_STAGES` cycles (plus 1 read cycle). CAP is set `pSYNC_STAGES`+1 cycles after the change, and `oIRQ` follows one cycle later.
- Bits above `pBITS` in writes are ignored; readback bits above `pBITS` are 0.
- Enabling both RISE and FALL on a bit captures either edge. Pulses shorter than one clock may be missed; this is accepted.

Test Plan:
1. Reset with `iPIO`=all-ones, release, and enable RISE=FALL=all-ones 2 cycles later. Wait 10 cycles → CAP reads 0 and `oIRQ`=0.
2. Write DATA=0x0000_00F0, SET=0x0F, CLR=0x30, TOGGLE=0x101 → `oPIO`=0x0000_01CE; reads of addr 2/3/4 return 0x1CE.
3. RISE=0x1, MASK=0x1, drive `iPIO`[0] 0→1 at cycle t → CAP[0]=1 at t+3, `oIRQ`=1 at t+4. Write CAP=0x1 → `oIRQ`=0 two cycles later.
4. FALL=0x2, MASK=0x2, with a falling edge on bit 1 arriving in the same cycle as a CAP W1C of 0x2 → CAP[1] stays 1 and `oIRQ` stays asserted.
5. Write MUX0=0xAAAA_AAAA and MUX1=0x5555_5555 → `oMUXSEL`={0x5555_5555,0xAAAA_AAAA}; readbacks match. Reads of addr 11..15 return 0 and writes there change nothing.
6. `pBITS`=8: write DATA=0xFFFF_FF5A → `oPIO`=0x5A and readback of addr 3 = 0x0000_005A. Assert `iRESET` mid-burst → all outputs 0 immediately (asynchronously).
